// File: rtl/ram_bist_master.sv
// March-free write/read BIST initiator for a single-port RAM: writes pattern^addr
// over the whole array, reads it back through an RD_LAT-deep compare pipeline.
module ram_bist_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX   = {(ADDR_W+1){1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [2:0]        DRAIN_END = 3'(RD_LAT - 1);

    // Zero-extend (or truncate) an address into a data word.
    function automatic logic [DATA_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+DATA_W-1:0] w;
        w = {{DATA_W{1'b0}}, a};
        return w[DATA_W-1:0];
    endfunction

    state_t              r_state;
    logic [DATA_W-1:0]   r_pattern;
    logic [2:0]          r_drain;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [ADDR_W:0]     r_fail_cnt;
    logic                r_ram_wr;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_datain;

    logic                r_pv [RD_LAT];
    logic [DATA_W-1:0]   r_pe [RD_LAT];
    logic [ADDR_W-1:0]   r_pa [RD_LAT];

    logic                w_start_ok;
    logic                w_mis;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic [ADDR_W-1:0]   w_addr_inc;

    assign w_addr_inc = r_ram_addr + ADDR_ONE;

    // Start acceptance, read-data compare and saturating mismatch count.
    always_comb begin
        w_start_ok = 1'b0;
        w_mis      = 1'b0;
        w_cnt_nxt  = r_fail_cnt;
        if (((r_state == IDLE) || (r_state == DONE)) && start) begin
            w_start_ok = 1'b1;
        end else begin
            w_start_ok = 1'b0;
        end
        if (r_pv[RD_LAT-1] && (ram_dataout != r_pe[RD_LAT-1])) begin
            w_mis = 1'b1;
        end else begin
            w_mis = 1'b0;
        end
        if (w_mis && (r_fail_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_fail_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_fail_cnt;
        end
    end

    // Expected word/address pipeline aligned with the RAM read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= DATA_ZERO;
                r_pa[i] <= ADDR_ZERO;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pa[i] <= r_pa[i-1];
            end
            r_pv[0] <= (r_state == READ);
            r_pe[0] <= r_pattern ^ addr_word(r_ram_addr);
            r_pa[0] <= r_ram_addr;
        end
    end

    // Run sequencer with registered RAM strobes and result flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pattern    <= DATA_ZERO;
            r_drain      <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_addr  <= ADDR_ZERO;
            r_fail_cnt   <= CNT_ZERO;
            r_ram_wr     <= 1'b0;
            r_ram_addr   <= ADDR_ZERO;
            r_ram_datain <= DATA_ZERO;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state      <= WRITE;
                        r_pattern    <= pattern;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_ram_wr     <= 1'b1;
                        r_ram_addr   <= ADDR_ZERO;
                        r_ram_datain <= pattern;
                    end else begin
                        r_state <= r_state;
                    end
                end
                WRITE: begin
                    if (r_ram_addr == ADDR_LAST) begin
                        r_state      <= READ;
                        r_ram_wr     <= 1'b0;
                        r_ram_addr   <= ADDR_ZERO;
                        r_ram_datain <= DATA_ZERO;
                    end else begin
                        r_ram_addr   <= w_addr_inc;
                        r_ram_datain <= r_pattern ^ addr_word(w_addr_inc);
                    end
                end
                READ: begin
                    if (r_ram_addr == ADDR_LAST) begin
                        r_state    <= DRAIN;
                        r_ram_addr <= ADDR_ZERO;
                        r_drain    <= 3'd0;
                    end else begin
                        r_ram_addr <= w_addr_inc;
                    end
                end
                DRAIN: begin
                    // The last compare lands on this edge, so pass uses the next count.
                    if (r_drain == DRAIN_END) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_cnt_nxt == CNT_ZERO);
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_ram_wr     <= 1'b0;
                    r_ram_addr   <= ADDR_ZERO;
                    r_ram_datain <= DATA_ZERO;
                end
            endcase

            if (w_start_ok) begin
                r_fail_cnt  <= CNT_ZERO;
                r_fail_addr <= ADDR_ZERO;
            end else if (w_mis) begin
                r_fail_cnt <= w_cnt_nxt;
                if (r_fail_cnt == CNT_ZERO) begin
                    r_fail_addr <= r_pa[RD_LAT-1];
                end else begin
                    r_fail_addr <= r_fail_addr;
                end
            end else begin
                r_fail_cnt <= r_fail_cnt;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_addr  = r_fail_addr;
    assign fail_cnt   = r_fail_cnt;
    assign ram_wr     = r_ram_wr;
    assign ram_addr   = r_ram_addr;
    assign ram_datain = r_ram_datain;

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed bench: a full-size instance (ADDR_W=13, RD_LAT=1) and a small
// instance (ADDR_W=4, RD_LAT=2) with a fault-injecting RAM model.
module tb_ram_bist_master;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Full-size instance
    logic        b_start = 1'b0;
    logic [15:0] b_pattern = 16'h0000;
    logic        b_busy, b_done, b_pass, b_ram_wr;
    logic [12:0] b_fail_addr, b_ram_addr;
    logic [13:0] b_fail_cnt;
    logic [15:0] b_ram_datain, b_ram_dataout;

    ram_bist_master #(.ADDR_W(13), .DATA_W(16), .RD_LAT(1)) u_big (
        .clk(clk), .reset(reset), .start(b_start), .pattern(b_pattern),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .fail_addr(b_fail_addr), .fail_cnt(b_fail_cnt),
        .ram_wr(b_ram_wr), .ram_addr(b_ram_addr),
        .ram_datain(b_ram_datain), .ram_dataout(b_ram_dataout)
    );

    // Small instance
    logic        s_start = 1'b0;
    logic [15:0] s_pattern = 16'h0000;
    logic        s_busy, s_done, s_pass, s_ram_wr;
    logic [3:0]  s_fail_addr, s_ram_addr;
    logic [4:0]  s_fail_cnt;
    logic [15:0] s_ram_datain, s_ram_dataout;
    int          s_mode = 0;

    ram_bist_master #(.ADDR_W(4), .DATA_W(16), .RD_LAT(2)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .pattern(s_pattern),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail_addr(s_fail_addr), .fail_cnt(s_fail_cnt),
        .ram_wr(s_ram_wr), .ram_addr(s_ram_addr),
        .ram_datain(s_ram_datain), .ram_dataout(s_ram_dataout)
    );

    // RAM models: big one has 1-cycle read, small one 2-cycle with faults
    logic [15:0] b_mem [0:8191];
    logic [15:0] b_q0;
    logic [15:0] s_mem [0:15];
    logic [15:0] s_q0, s_q1;

    function automatic logic [15:0] s_fault(input logic [15:0] v, input logic [3:0] a);
        case (s_mode)
            1:       return (a == 4'd6) ? (v | 16'h0001) : v;
            2:       return 16'hFFFF;
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (b_ram_wr) b_mem[b_ram_addr] <= b_ram_datain;
        b_q0 <= b_mem[b_ram_addr];
        if (s_ram_wr) s_mem[s_ram_addr] <= s_ram_datain;
        s_q0 <= s_fault(s_mem[s_ram_addr], s_ram_addr);
        s_q1 <= s_q0;
    end
    assign b_ram_dataout = b_q0;
    assign s_ram_dataout = s_q1;

    // Bus monitors: write counts, addr-5 data, protocol violations
    int          b_wr_total = 0, b_viol = 0, s_viol = 0;
    logic [15:0] b_d5 = 16'h0000;
    logic        b_pwr = 1'b0, b_pbusy = 1'b0, s_pwr = 1'b0, s_pbusy = 1'b0;
    logic [12:0] b_paddr = 13'd0;
    logic [3:0]  s_paddr = 4'd0;

    always @(negedge clk) begin
        if (b_ram_wr) begin
            b_wr_total++;
            if (b_ram_addr == 13'd5) b_d5 = b_ram_datain;
        end
        if (b_ram_wr && !b_busy) b_viol++;
        if (!b_busy && (b_ram_addr != 13'd0 || b_ram_datain != 16'h0000)) b_viol++;
        if (b_ram_wr && b_pwr && (b_ram_addr != b_paddr + 13'd1)) b_viol++;
        if (!b_ram_wr && b_busy && b_pbusy && !b_pwr && b_ram_addr != 13'd0 &&
            (b_ram_addr != b_paddr + 13'd1)) b_viol++;
        b_pwr = b_ram_wr; b_pbusy = b_busy; b_paddr = b_ram_addr;

        if (s_ram_wr && !s_busy) s_viol++;
        if (!s_busy && (s_ram_addr != 4'd0 || s_ram_datain != 16'h0000)) s_viol++;
        if (s_ram_wr && s_pwr && (s_ram_addr != s_paddr + 4'd1)) s_viol++;
        if (!s_ram_wr && s_busy && s_pbusy && !s_pwr && s_ram_addr != 4'd0 &&
            (s_ram_addr != s_paddr + 4'd1)) s_viol++;
        s_pwr = s_ram_wr; s_pbusy = s_busy; s_paddr = s_ram_addr;
    end

    task automatic run_small(input logic [15:0] pat, input int mode, output int cyc);
        s_mode = mode;
        s_pattern = pat;
        @(negedge clk); s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        cyc = s_busy ? 1 : 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (s_done) break;
            if (s_busy) cyc++;
        end
    endtask

    task automatic test_reset();
        #2; reset = 1'b0; #1;
        total++;
        if ({b_busy, b_done, b_pass, b_fail_addr, b_fail_cnt, b_ram_wr, b_ram_addr, b_ram_datain} !== 65'd0) begin
            bad++; $display("FAIL reset_big: got outputs nonzero busy=%b wr=%b addr=%0h", b_busy, b_ram_wr, b_ram_addr);
        end
        total++;
        if ({s_busy, s_done, s_pass, s_fail_addr, s_fail_cnt, s_ram_wr, s_ram_addr, s_ram_datain} !== 44'd0) begin
            bad++; $display("FAIL reset_small: got outputs nonzero busy=%b wr=%b addr=%0h", s_busy, s_ram_wr, s_ram_addr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({b_ram_wr, s_ram_wr, b_busy, s_busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_release: got wr/busy=%b want 0000", {b_ram_wr, s_ram_wr, b_busy, s_busy});
        end
    endtask

    task automatic test_abort();
        int wr0;
        b_pattern = 16'h1234;
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        repeat (99) @(posedge clk);
        #1; reset = 1'b0; #1;
        total++;
        if ({b_busy, b_done, b_pass, b_fail_addr, b_fail_cnt, b_ram_wr, b_ram_addr, b_ram_datain} !== 65'd0) begin
            bad++; $display("FAIL abort_outputs: got busy=%b wr=%b addr=%0h data=%0h want all 0",
                            b_busy, b_ram_wr, b_ram_addr, b_ram_datain);
        end
        wr0 = b_wr_total;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (b_wr_total !== wr0) begin
            bad++; $display("FAIL abort_no_write: got %0d writes want 0", b_wr_total - wr0);
        end
        total++;
        if ({b_busy, b_done} !== 2'b00) begin
            bad++; $display("FAIL abort_idle: got busy/done=%b want 00", {b_busy, b_done});
        end
    endtask

    task automatic test_big_pass();
        int cyc, wr0;
        wr0 = b_wr_total;
        b_pattern = 16'hA5A5;
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        cyc = b_busy ? 1 : 0;
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk); #1;
            if (b_done) break;
            if (b_busy) cyc++;
        end
        total++;
        if (cyc !== 16385 || b_done !== 1'b1) begin
            bad++; $display("FAIL big_busy: got %0d cycles done=%b want 16385 done=1", cyc, b_done);
        end
        total++;
        if (b_pass !== 1'b1 || b_fail_cnt !== 14'd0) begin
            bad++; $display("FAIL big_pass: got pass=%b cnt=%0d want 1/0", b_pass, b_fail_cnt);
        end
        total++;
        if (b_wr_total - wr0 !== 8192) begin
            bad++; $display("FAIL big_writes: got %0d want 8192", b_wr_total - wr0);
        end
        total++;
        if (b_d5 !== 16'hA5A0) begin
            bad++; $display("FAIL big_addr5: got %h want a5a0", b_d5);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({b_done, b_pass, b_busy} !== 3'b110) begin
            bad++; $display("FAIL big_hold: got done/pass/busy=%b want 110", {b_done, b_pass, b_busy});
        end
    endtask

    task automatic test_stuck();
        int cyc;
        run_small(16'h0000, 1, cyc);
        total++;
        if (cyc !== 34) begin
            bad++; $display("FAIL stuck_busy: got %0d want 34", cyc);
        end
        total++;
        if ({s_pass, s_fail_addr, s_fail_cnt} !== {1'b0, 4'd6, 5'd1}) begin
            bad++; $display("FAIL stuck_result: got pass=%b addr=%0d cnt=%0d want 0/6/1", s_pass, s_fail_addr, s_fail_cnt);
        end
    endtask

    task automatic test_all_ones();
        int cyc;
        // Only the word equal to 16'hFFFF can match: with pattern FFF0 that is addr 15.
        run_small(16'hFFF0, 2, cyc);
        total++;
        if ({s_pass, s_fail_addr, s_fail_cnt} !== {1'b0, 4'd0, 5'd15}) begin
            bad++; $display("FAIL ones_fff0: got pass=%b addr=%0d cnt=%0d want 0/0/15", s_pass, s_fail_addr, s_fail_cnt);
        end
        run_small(16'h0000, 2, cyc);
        total++;
        if ({s_pass, s_fail_addr, s_fail_cnt} !== {1'b0, 4'd0, 5'd16}) begin
            bad++; $display("FAIL ones_0000: got pass=%b addr=%0d cnt=%0d want 0/0/16", s_pass, s_fail_addr, s_fail_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_small(16'h3C5A, 0, cyc);
        total++;
        if ({s_pass, s_fail_cnt} !== {1'b1, 5'd0} || cyc !== 34) begin
            bad++; $display("FAIL b2b_pass: got pass=%b cnt=%0d cyc=%0d want 1/0/34", s_pass, s_fail_cnt, cyc);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        s_mode = 1;
        s_pattern = 16'h0000;
        @(negedge clk); s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        cyc = s_busy ? 1 : 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (s_done) break;
            if (s_busy) cyc++;
            if (cyc == 20) s_start = 1'b1;
            else if (cyc == 21) s_start = 1'b0;
            else if (cyc == 30) s_start = 1'b1;
        end
        total++;
        if (cyc !== 34 || s_done !== 1'b1 || s_fail_cnt !== 5'd1) begin
            bad++; $display("FAIL ign_run: got cyc=%0d done=%b cnt=%0d want 34/1/1", cyc, s_done, s_fail_cnt);
        end
        @(posedge clk); #1;
        s_start = 1'b0;
        total++;
        if ({s_done, s_busy, s_fail_cnt} !== {1'b0, 1'b1, 5'd0}) begin
            bad++; $display("FAIL ign_restart: got done=%b busy=%b cnt=%0d want 0/1/0", s_done, s_busy, s_fail_cnt);
        end
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (s_done) break;
        end
        total++;
        if ({s_done, s_fail_addr, s_fail_cnt} !== {1'b1, 4'd6, 5'd1}) begin
            bad++; $display("FAIL ign_second: got done=%b addr=%0d cnt=%0d want 1/6/1", s_done, s_fail_addr, s_fail_cnt);
        end
    endtask

    task automatic test_protocol();
        total++;
        if (b_viol !== 0) begin
            bad++; $display("FAIL big_protocol: got %0d violations want 0", b_viol);
        end
        total++;
        if (s_viol !== 0) begin
            bad++; $display("FAIL small_protocol: got %0d violations want 0", s_viol);
        end
    endtask

    initial begin
        test_reset();
        test_abort();
        test_big_pass();
        test_stuck();
        test_all_ones();
        test_back_to_back();
        test_start_ignored();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
